// File: rtl/issue_queue_if.sv
// Dispatch, completion-broadcast and issue-port bundle for the issue queue.
// master is the surrounding pipeline; slave is the queue itself.
interface issue_queue_if #(
  parameter int NUM_FU = 3,
  parameter int CBW    = 2,
  parameter int TAG_W  = 6,
  parameter int ROB_W  = 4,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 32,
  parameter int FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
);
  logic [1:0]               disp_valid;
  logic                     disp_ready;
  logic [2*TAG_W-1:0]       disp_src1_tag;
  logic [2*TAG_W-1:0]       disp_src2_tag;
  logic [1:0]               disp_src1_rdy;
  logic [1:0]               disp_src2_rdy;
  logic [2*DATA_W-1:0]      disp_src1_val;
  logic [2*DATA_W-1:0]      disp_src2_val;
  logic [2*TAG_W-1:0]       disp_dst_tag;
  logic [2*ROB_W-1:0]       disp_rob;
  logic [2*FU_W-1:0]        disp_fu;
  logic [2*CTRL_W-1:0]      disp_ctrl;

  logic [CBW-1:0]           wb_valid;
  logic [CBW*TAG_W-1:0]     wb_tag;
  logic [CBW*DATA_W-1:0]    wb_val;

  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_FU-1:0]        iss_valid;
  logic [NUM_FU*DATA_W-1:0] iss_src1_val;
  logic [NUM_FU*DATA_W-1:0] iss_src2_val;
  logic [NUM_FU*TAG_W-1:0]  iss_dst_tag;
  logic [NUM_FU*ROB_W-1:0]  iss_rob;
  logic [NUM_FU*CTRL_W-1:0] iss_ctrl;

  modport master (
    output disp_valid, disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
           disp_src1_val, disp_src2_val, disp_dst_tag, disp_rob, disp_fu, disp_ctrl,
           wb_valid, wb_tag, wb_val, fu_ready,
    input  disp_ready, iss_valid, iss_src1_val, iss_src2_val, iss_dst_tag, iss_rob, iss_ctrl
  );

  modport slave (
    input  disp_valid, disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
           disp_src1_val, disp_src2_val, disp_dst_tag, disp_rob, disp_fu, disp_ctrl,
           wb_valid, wb_tag, wb_val, fu_ready,
    output disp_ready, iss_valid, iss_src1_val, iss_src2_val, iss_dst_tag, iss_rob, iss_ctrl
  );
endinterface

// File: rtl/issue_queue.sv
// Out-of-order reservation station: dual dispatch, broadcast wakeup with
// dispatch bypass, and oldest-first select per functional unit via an age matrix.
module issue_queue #(
  parameter int DEPTH  = 16,
  parameter int NUM_FU = 3,
  parameter int CBW    = 2,
  parameter int TAG_W  = 6,
  parameter int ROB_W  = 4,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 32,
  parameter int FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  parameter int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  issue_queue_if.slave     iq,
  output logic [OCC_W-1:0] occupancy
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
  logic [TAG_W-1:0]  s1_tag_q [DEPTH];
  logic [TAG_W-1:0]  s1_tag_d [DEPTH];
  logic [TAG_W-1:0]  s2_tag_q [DEPTH];
  logic [TAG_W-1:0]  s2_tag_d [DEPTH];
  logic [DATA_W-1:0] s1_val_q [DEPTH];
  logic [DATA_W-1:0] s1_val_d [DEPTH];
  logic [DATA_W-1:0] s2_val_q [DEPTH];
  logic [DATA_W-1:0] s2_val_d [DEPTH];
  logic [TAG_W-1:0]  dst_q [DEPTH];
  logic [TAG_W-1:0]  dst_d [DEPTH];
  logic [ROB_W-1:0]  rob_q [DEPTH];
  logic [ROB_W-1:0]  rob_d [DEPTH];
  logic [FU_W-1:0]   fu_q [DEPTH];
  logic [FU_W-1:0]   fu_d [DEPTH];
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  // older_q[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DEPTH-1:0]  older_d [DEPTH];
  logic [OCC_W-1:0]  occ_q, occ_d;

  logic [NUM_FU-1:0] iss_valid_q, iss_valid_d;
  logic [DATA_W-1:0] iss_s1_q [NUM_FU];
  logic [DATA_W-1:0] iss_s1_d [NUM_FU];
  logic [DATA_W-1:0] iss_s2_q [NUM_FU];
  logic [DATA_W-1:0] iss_s2_d [NUM_FU];
  logic [TAG_W-1:0]  iss_dst_q [NUM_FU];
  logic [TAG_W-1:0]  iss_dst_d [NUM_FU];
  logic [ROB_W-1:0]  iss_rob_q [NUM_FU];
  logic [ROB_W-1:0]  iss_rob_d [NUM_FU];
  logic [CTRL_W-1:0] iss_ctrl_q [NUM_FU];
  logic [CTRL_W-1:0] iss_ctrl_d [NUM_FU];

  logic              disp_ready;
  logic [1:0]        acc;
  logic [1:0]        d_s1_rdy, d_s2_rdy;
  logic [DATA_W-1:0] d_s1_val [2];
  logic [DATA_W-1:0] d_s2_val [2];
  logic [IDX_W-1:0]  first_free, second_free;
  logic              found0, found1;
  logic [IDX_W-1:0]  alloc_idx [2];
  logic [DEPTH-1:0]  cand [NUM_FU];
  logic [DEPTH-1:0]  oldest [NUM_FU];
  logic [NUM_FU-1:0] fire;
  logic [IDX_W-1:0]  sel_idx [NUM_FU];
  logic [OCC_W-1:0]  n_iss;

  assign disp_ready    = (occ_q <= OCC_W'(DEPTH - 2));
  assign iq.disp_ready = disp_ready;
  assign occupancy     = occ_q;
  assign iq.iss_valid  = iss_valid_q;

  for (genvar k = 0; k < NUM_FU; k++) begin : g_out
    assign iq.iss_src1_val[k*DATA_W +: DATA_W] = iss_s1_q[k];
    assign iq.iss_src2_val[k*DATA_W +: DATA_W] = iss_s2_q[k];
    assign iq.iss_dst_tag[k*TAG_W +: TAG_W]    = iss_dst_q[k];
    assign iq.iss_rob[k*ROB_W +: ROB_W]        = iss_rob_q[k];
    assign iq.iss_ctrl[k*CTRL_W +: CTRL_W]     = iss_ctrl_q[k];
  end

  // Descending broadcast scan so the lowest-numbered matching port wins
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      acc[s]      = iq.disp_valid[s] && disp_ready && !flush;
      d_s1_rdy[s] = iq.disp_src1_rdy[s];
      d_s2_rdy[s] = iq.disp_src2_rdy[s];
      d_s1_val[s] = iq.disp_src1_val[s*DATA_W +: DATA_W];
      d_s2_val[s] = iq.disp_src2_val[s*DATA_W +: DATA_W];
      for (int j = CBW - 1; j >= 0; j--) begin
        if (iq.wb_valid[j] && !iq.disp_src1_rdy[s] &&
            iq.wb_tag[j*TAG_W +: TAG_W] == iq.disp_src1_tag[s*TAG_W +: TAG_W]) begin
          d_s1_rdy[s] = 1'b1;
          d_s1_val[s] = iq.wb_val[j*DATA_W +: DATA_W];
        end
        if (iq.wb_valid[j] && !iq.disp_src2_rdy[s] &&
            iq.wb_tag[j*TAG_W +: TAG_W] == iq.disp_src2_tag[s*TAG_W +: TAG_W]) begin
          d_s2_rdy[s] = 1'b1;
          d_s2_val[s] = iq.wb_val[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    first_free  = '0;
    second_free = '0;
    found0      = 1'b0;
    found1      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i]) begin
        if (!found0) begin
          first_free = IDX_W'(i);
          found0     = 1'b1;
        end else if (!found1) begin
          second_free = IDX_W'(i);
          found1      = 1'b1;
        end
      end
    end
    alloc_idx[0] = first_free;
    alloc_idx[1] = acc[0] ? second_free : first_free;
  end

  // An entry is oldest for its FU when no other candidate of that FU is older
  always_comb begin
    n_iss = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        cand[k][i] = valid_q[i] && s1_rdy_q[i] && s2_rdy_q[i] && (fu_q[i] == FU_W'(k));
      end
      sel_idx[k] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        oldest[k][i] = cand[k][i];
        for (int j = 0; j < DEPTH; j++) begin
          if (cand[k][j] && older_q[j][i]) oldest[k][i] = 1'b0;
        end
        if (oldest[k][i]) sel_idx[k] = IDX_W'(i);
      end
      fire[k] = (|oldest[k]) && iq.fu_ready[k] && !flush;
      n_iss   = n_iss + OCC_W'(fire[k]);
    end
  end

  always_comb begin
    valid_d  = valid_q;
    s1_rdy_d = s1_rdy_q;
    s2_rdy_d = s2_rdy_q;
    s1_tag_d = s1_tag_q;
    s2_tag_d = s2_tag_q;
    s1_val_d = s1_val_q;
    s2_val_d = s2_val_q;
    dst_d    = dst_q;
    rob_d    = rob_q;
    fu_d     = fu_q;
    ctrl_d   = ctrl_q;
    older_d  = older_q;
    iss_valid_d = fire;
    iss_s1_d    = iss_s1_q;
    iss_s2_d    = iss_s2_q;
    iss_dst_d   = iss_dst_q;
    iss_rob_d   = iss_rob_q;
    iss_ctrl_d  = iss_ctrl_q;

    if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = CBW - 1; j >= 0; j--) begin
          if (valid_q[i] && iq.wb_valid[j] && !s1_rdy_q[i] &&
              iq.wb_tag[j*TAG_W +: TAG_W] == s1_tag_q[i]) begin
            s1_rdy_d[i] = 1'b1;
            s1_val_d[i] = iq.wb_val[j*DATA_W +: DATA_W];
          end
          if (valid_q[i] && iq.wb_valid[j] && !s2_rdy_q[i] &&
              iq.wb_tag[j*TAG_W +: TAG_W] == s2_tag_q[i]) begin
            s2_rdy_d[i] = 1'b1;
            s2_val_d[i] = iq.wb_val[j*DATA_W +: DATA_W];
          end
        end
      end
    end

    for (int k = 0; k < NUM_FU; k++) begin
      if (fire[k]) begin
        valid_d[sel_idx[k]] = 1'b0;
        iss_s1_d[k]   = s1_val_q[sel_idx[k]];
        iss_s2_d[k]   = s2_val_q[sel_idx[k]];
        iss_dst_d[k]  = dst_q[sel_idx[k]];
        iss_rob_d[k]  = rob_q[sel_idx[k]];
        iss_ctrl_d[k] = ctrl_q[sel_idx[k]];
      end
    end

    // Slot 0 is written first so slot 1 ends up younger than it
    for (int s = 0; s < 2; s++) begin
      if (acc[s]) begin
        valid_d[alloc_idx[s]]  = 1'b1;
        s1_tag_d[alloc_idx[s]] = iq.disp_src1_tag[s*TAG_W +: TAG_W];
        s2_tag_d[alloc_idx[s]] = iq.disp_src2_tag[s*TAG_W +: TAG_W];
        s1_rdy_d[alloc_idx[s]] = d_s1_rdy[s];
        s2_rdy_d[alloc_idx[s]] = d_s2_rdy[s];
        s1_val_d[alloc_idx[s]] = d_s1_val[s];
        s2_val_d[alloc_idx[s]] = d_s2_val[s];
        dst_d[alloc_idx[s]]    = iq.disp_dst_tag[s*TAG_W +: TAG_W];
        rob_d[alloc_idx[s]]    = iq.disp_rob[s*ROB_W +: ROB_W];
        fu_d[alloc_idx[s]]     = iq.disp_fu[s*FU_W +: FU_W];
        ctrl_d[alloc_idx[s]]   = iq.disp_ctrl[s*CTRL_W +: CTRL_W];
        older_d[alloc_idx[s]]  = '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (IDX_W'(j) != alloc_idx[s]) older_d[j][alloc_idx[s]] = 1'b1;
        end
      end
    end

    occ_d = occ_q + OCC_W'(acc[0]) + OCC_W'(acc[1]) - n_iss;
    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      s1_rdy_q    <= '0;
      s2_rdy_q    <= '0;
      occ_q       <= '0;
      iss_valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        s1_tag_q[i] <= '0;
        s2_tag_q[i] <= '0;
        s1_val_q[i] <= '0;
        s2_val_q[i] <= '0;
        dst_q[i]    <= '0;
        rob_q[i]    <= '0;
        fu_q[i]     <= '0;
        ctrl_q[i]   <= '0;
        older_q[i]  <= '0;
      end
      for (int k = 0; k < NUM_FU; k++) begin
        iss_s1_q[k]   <= '0;
        iss_s2_q[k]   <= '0;
        iss_dst_q[k]  <= '0;
        iss_rob_q[k]  <= '0;
        iss_ctrl_q[k] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      s1_rdy_q    <= s1_rdy_d;
      s2_rdy_q    <= s2_rdy_d;
      occ_q       <= occ_d;
      iss_valid_q <= iss_valid_d;
      s1_tag_q    <= s1_tag_d;
      s2_tag_q    <= s2_tag_d;
      s1_val_q    <= s1_val_d;
      s2_val_q    <= s2_val_d;
      dst_q       <= dst_d;
      rob_q       <= rob_d;
      fu_q        <= fu_d;
      ctrl_q      <= ctrl_d;
      older_q     <= older_d;
      iss_s1_q    <= iss_s1_d;
      iss_s2_q    <= iss_s2_d;
      iss_dst_q   <= iss_dst_d;
      iss_rob_q   <= iss_rob_d;
      iss_ctrl_q  <= iss_ctrl_d;
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: one task per scenario with hand-computed
// expectations; inputs change and outputs are sampled on the falling edge.
module tb_issue_queue;
  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [4:0] occupancy;
  int n_checks = 0;
  int n_fail   = 0;

  issue_queue_if iq ();

  issue_queue dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .iq        (iq),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    iq.disp_valid    = '0;
    iq.disp_src1_tag = '0;
    iq.disp_src2_tag = '0;
    iq.disp_src1_rdy = '0;
    iq.disp_src2_rdy = '0;
    iq.disp_src1_val = '0;
    iq.disp_src2_val = '0;
    iq.disp_dst_tag  = '0;
    iq.disp_rob      = '0;
    iq.disp_fu       = '0;
    iq.disp_ctrl     = '0;
    iq.wb_valid      = '0;
    iq.wb_tag        = '0;
    iq.wb_val        = '0;
  endtask

  task automatic drive_slot(input int s, input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                            input logic [5:0] t2, input logic r2, input logic [31:0] v2,
                            input logic [5:0] dst, input logic [3:0] rob, input logic [1:0] fu);
    iq.disp_valid[s]           = 1'b1;
    iq.disp_src1_tag[s*6 +: 6] = t1;
    iq.disp_src1_rdy[s]        = r1;
    iq.disp_src1_val[s*32 +: 32] = v1;
    iq.disp_src2_tag[s*6 +: 6] = t2;
    iq.disp_src2_rdy[s]        = r2;
    iq.disp_src2_val[s*32 +: 32] = v2;
    iq.disp_dst_tag[s*6 +: 6]  = dst;
    iq.disp_rob[s*4 +: 4]      = rob;
    iq.disp_fu[s*2 +: 2]       = fu;
    iq.disp_ctrl[s*32 +: 32]   = {16'hC0DE, 10'd0, dst};
  endtask

  task automatic drive_wb(input int j, input logic [5:0] tag, input logic [31:0] val);
    iq.wb_valid[j]        = 1'b1;
    iq.wb_tag[j*6 +: 6]   = tag;
    iq.wb_val[j*32 +: 32] = val;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_occ: got %0d want 0", occupancy); end
    n_checks++; if (iq.disp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_disp_ready: got %b want 1", iq.disp_ready); end
    n_checks++; if (iq.iss_valid !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_iss_valid: got %b want 000", iq.iss_valid); end
    n_checks++; if (iq.iss_src1_val !== 96'd0) begin n_fail++; $display("[TB] FAIL reset_iss_data: got %h want 0", iq.iss_src1_val); end
    reset = 1'b0;
    step();
    n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("[TB] FAIL post_reset_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_dual_dispatch();
    iq.fu_ready = 3'b111;
    drive_slot(0, 6'd1, 1'b1, 32'h11, 6'd2, 1'b1, 32'h22, 6'd10, 4'd1, 2'd0);
    drive_slot(1, 6'd3, 1'b1, 32'h33, 6'd4, 1'b1, 32'h44, 6'd11, 4'd2, 2'd1);
    step();
    clear_inputs();
    n_checks++; if (occupancy !== 5'd2) begin n_fail++; $display("[TB] FAIL dual_occ_written: got %0d want 2", occupancy); end
    n_checks++; if (iq.iss_valid !== 3'b000) begin n_fail++; $display("[TB] FAIL dual_no_early_issue: got %b want 000", iq.iss_valid); end
    step();
    n_checks++; if (iq.iss_valid !== 3'b011) begin n_fail++; $display("[TB] FAIL dual_iss_valid: got %b want 011", iq.iss_valid); end
    n_checks++; if (iq.iss_src1_val[31:0] !== 32'h11 || iq.iss_src2_val[31:0] !== 32'h22) begin n_fail++; $display("[TB] FAIL dual_p0_vals: got %h/%h want 11/22", iq.iss_src1_val[31:0], iq.iss_src2_val[31:0]); end
    n_checks++; if (iq.iss_dst_tag[5:0] !== 6'd10 || iq.iss_rob[3:0] !== 4'd1) begin n_fail++; $display("[TB] FAIL dual_p0_dst_rob: got %0d/%0d want 10/1", iq.iss_dst_tag[5:0], iq.iss_rob[3:0]); end
    n_checks++; if (iq.iss_ctrl[31:0] !== 32'hC0DE000A) begin n_fail++; $display("[TB] FAIL dual_p0_ctrl: got %h want C0DE000A", iq.iss_ctrl[31:0]); end
    n_checks++; if (iq.iss_src1_val[63:32] !== 32'h33 || iq.iss_src2_val[63:32] !== 32'h44) begin n_fail++; $display("[TB] FAIL dual_p1_vals: got %h/%h want 33/44", iq.iss_src1_val[63:32], iq.iss_src2_val[63:32]); end
    n_checks++; if (iq.iss_dst_tag[11:6] !== 6'd11 || iq.iss_rob[7:4] !== 4'd2) begin n_fail++; $display("[TB] FAIL dual_p1_dst_rob: got %0d/%0d want 11/2", iq.iss_dst_tag[11:6], iq.iss_rob[7:4]); end
    n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("[TB] FAIL dual_occ_drained: got %0d want 0", occupancy); end
    step();
    n_checks++; if (iq.iss_valid !== 3'b000) begin n_fail++; $display("[TB] FAIL dual_pulse_one_cycle: got %b want 000", iq.iss_valid); end
  endtask

  task automatic test_wakeup();
    drive_slot(0, 6'd5, 1'b0, 32'h0BAD0000, 6'd4, 1'b1, 32'h7, 6'd12, 4'd3, 2'd0);
    step();
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (iq.iss_valid[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL wake_wait_%0d: got %b want 0", c, iq.iss_valid[0]); end
      if (c < 2) step();
    end
    drive_wb(0, 6'd5, 32'hDEADBEEF);
    drive_wb(1, 6'd5, 32'h00000BAD);
    step();
    clear_inputs();
    n_checks++; if (iq.iss_valid[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL wake_no_same_cycle_issue: got %b want 0", iq.iss_valid[0]); end
    step();
    n_checks++; if (iq.iss_valid[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL wake_iss_valid: got %b want 1", iq.iss_valid[0]); end
    n_checks++; if (iq.iss_src1_val[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL wake_src1_val: got %h want DEADBEEF", iq.iss_src1_val[31:0]); end
    n_checks++; if (iq.iss_src2_val[31:0] !== 32'h7 || iq.iss_dst_tag[5:0] !== 6'd12) begin n_fail++; $display("[TB] FAIL wake_src2_dst: got %h/%0d want 7/12", iq.iss_src2_val[31:0], iq.iss_dst_tag[5:0]); end
    step();
  endtask

  task automatic test_bypass();
    drive_slot(0, 6'd3, 1'b1, 32'hA, 6'd9, 1'b0, 32'hFFFF, 6'd13, 4'd5, 2'd2);
    drive_wb(0, 6'd8, 32'h5555);
    drive_wb(1, 6'd9, 32'h1234);
    step();
    clear_inputs();
    n_checks++; if (occupancy !== 5'd1) begin n_fail++; $display("[TB] FAIL bypass_occ: got %0d want 1", occupancy); end
    step();
    n_checks++; if (iq.iss_valid !== 3'b100) begin n_fail++; $display("[TB] FAIL bypass_iss_valid: got %b want 100", iq.iss_valid); end
    n_checks++; if (iq.iss_src2_val[95:64] !== 32'h1234 || iq.iss_src1_val[95:64] !== 32'hA) begin n_fail++; $display("[TB] FAIL bypass_vals: got %h/%h want A/1234", iq.iss_src1_val[95:64], iq.iss_src2_val[95:64]); end
    step();
  endtask

  task automatic test_age_order();
    logic [5:0] exp_dst [4];
    exp_dst = '{6'd20, 6'd22, 6'd23, 6'd24};
    iq.fu_ready = 3'b110;
    drive_slot(0, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'd20, 4'd4, 2'd0);
    drive_slot(1, 6'd0, 1'b1, 32'h3, 6'd0, 1'b1, 32'h4, 6'd21, 4'd5, 2'd1);
    step();
    clear_inputs();
    drive_slot(1, 6'd0, 1'b1, 32'h5, 6'd0, 1'b1, 32'h6, 6'd22, 4'd6, 2'd0);
    step();
    clear_inputs();
    n_checks++; if (iq.iss_valid !== 3'b010 || iq.iss_dst_tag[11:6] !== 6'd21) begin n_fail++; $display("[TB] FAIL age_fu1_issue: got %b/%0d want 010/21", iq.iss_valid, iq.iss_dst_tag[11:6]); end
    drive_slot(0, 6'd0, 1'b1, 32'h7, 6'd0, 1'b1, 32'h8, 6'd23, 4'd7, 2'd0);
    drive_slot(1, 6'd0, 1'b1, 32'h9, 6'd0, 1'b1, 32'hA, 6'd24, 4'd8, 2'd0);
    step();
    clear_inputs();
    n_checks++; if (occupancy !== 5'd4 || iq.iss_valid !== 3'b000) begin n_fail++; $display("[TB] FAIL age_held: got occ %0d valid %b want 4/000", occupancy, iq.iss_valid); end
    iq.fu_ready = 3'b111;
    for (int n = 0; n < 4; n++) begin
      step();
      n_checks++; if (iq.iss_valid[0] !== 1'b1 || iq.iss_dst_tag[5:0] !== exp_dst[n]) begin n_fail++; $display("[TB] FAIL age_order_%0d: got %b/%0d want 1/%0d", n, iq.iss_valid[0], iq.iss_dst_tag[5:0], exp_dst[n]); end
    end
    step();
    n_checks++; if (occupancy !== 5'd0 || iq.iss_valid !== 3'b000) begin n_fail++; $display("[TB] FAIL age_drained: got occ %0d valid %b want 0/000", occupancy, iq.iss_valid); end
  endtask

  task automatic test_full();
    iq.fu_ready = 3'b000;
    for (int p = 0; p < 7; p++) begin
      clear_inputs();
      drive_slot(0, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'(2*p), 4'd0, 2'd0);
      drive_slot(1, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'(2*p+1), 4'd0, 2'd0);
      step();
    end
    clear_inputs();
    n_checks++; if (occupancy !== 5'd14 || iq.disp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL full_14: got occ %0d ready %b want 14/1", occupancy, iq.disp_ready); end
    drive_slot(0, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'd14, 4'd0, 2'd0);
    step();
    clear_inputs();
    n_checks++; if (occupancy !== 5'd15 || iq.disp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_15: got occ %0d ready %b want 15/0", occupancy, iq.disp_ready); end
    drive_slot(0, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'd40, 4'd0, 2'd0);
    drive_slot(1, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'd41, 4'd0, 2'd0);
    step();
    n_checks++; if (occupancy !== 5'd15) begin n_fail++; $display("[TB] FAIL full_reject: got occ %0d want 15", occupancy); end
    iq.fu_ready = 3'b001;
    step();
    iq.fu_ready = 3'b000;
    clear_inputs();
    n_checks++; if (iq.iss_valid[0] !== 1'b1 || iq.iss_dst_tag[5:0] !== 6'd0) begin n_fail++; $display("[TB] FAIL full_issue_oldest: got %b/%0d want 1/0", iq.iss_valid[0], iq.iss_dst_tag[5:0]); end
    n_checks++; if (occupancy !== 5'd14 || iq.disp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL full_freed: got occ %0d ready %b want 14/1", occupancy, iq.disp_ready); end
    drive_slot(0, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'd15, 4'd0, 2'd0);
    drive_slot(1, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'd16, 4'd0, 2'd0);
    step();
    clear_inputs();
    n_checks++; if (occupancy !== 5'd16 || iq.disp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_16: got occ %0d ready %b want 16/0", occupancy, iq.disp_ready); end
    iq.fu_ready = 3'b001;
    for (int k = 1; k <= 16; k++) begin
      step();
      n_checks++; if (iq.iss_valid[0] !== 1'b1 || iq.iss_dst_tag[5:0] !== 6'(k)) begin n_fail++; $display("[TB] FAIL full_drain_%0d: got %b/%0d want 1/%0d", k, iq.iss_valid[0], iq.iss_dst_tag[5:0], k); end
    end
    step();
    n_checks++; if (occupancy !== 5'd0 || iq.iss_valid !== 3'b000) begin n_fail++; $display("[TB] FAIL full_empty: got occ %0d valid %b want 0/000", occupancy, iq.iss_valid); end
  endtask

  task automatic test_flush();
    iq.fu_ready = 3'b000;
    for (int p = 0; p < 2; p++) begin
      clear_inputs();
      drive_slot(0, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'(30+2*p), 4'd0, 2'd0);
      drive_slot(1, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'(31+2*p), 4'd0, 2'd1);
      step();
    end
    clear_inputs();
    n_checks++; if (occupancy !== 5'd4) begin n_fail++; $display("[TB] FAIL flush_pre_occ: got %0d want 4", occupancy); end
    flush = 1'b1;
    iq.fu_ready = 3'b111;
    drive_slot(0, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'd38, 4'd0, 2'd0);
    drive_slot(1, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'd39, 4'd0, 2'd2);
    drive_wb(0, 6'd7, 32'h77);
    step();
    flush = 1'b0;
    clear_inputs();
    n_checks++; if (occupancy !== 5'd0 || iq.iss_valid !== 3'b000) begin n_fail++; $display("[TB] FAIL flush_cleared: got occ %0d valid %b want 0/000", occupancy, iq.iss_valid); end
    step();
    n_checks++; if (occupancy !== 5'd0 || iq.iss_valid !== 3'b000 || iq.disp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_after: got occ %0d valid %b ready %b want 0/000/1", occupancy, iq.iss_valid, iq.disp_ready); end
  endtask

  task automatic test_reset_mid();
    iq.fu_ready = 3'b111;
    drive_slot(0, 6'd0, 1'b1, 32'h51, 6'd0, 1'b1, 32'h52, 6'd50, 4'd9, 2'd0);
    drive_slot(1, 6'd0, 1'b1, 32'h53, 6'd0, 1'b1, 32'h54, 6'd51, 4'd10, 2'd1);
    step();
    clear_inputs();
    step();
    n_checks++; if (iq.iss_valid !== 3'b011) begin n_fail++; $display("[TB] FAIL midrst_pre_issue: got %b want 011", iq.iss_valid); end
    drive_slot(0, 6'd0, 1'b1, 32'h61, 6'd0, 1'b1, 32'h62, 6'd52, 4'd11, 2'd0);
    step();
    reset = 1'b1;
    #1;
    n_checks++; if (iq.iss_valid !== 3'b000 || occupancy !== 5'd0) begin n_fail++; $display("[TB] FAIL midrst_immediate: got valid %b occ %0d want 000/0", iq.iss_valid, occupancy); end
    n_checks++; if (iq.iss_dst_tag !== 18'd0 || iq.iss_src1_val !== 96'd0 || iq.disp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_data: got dst %h src1 %h ready %b want 0/0/1", iq.iss_dst_tag, iq.iss_src1_val, iq.disp_ready); end
    step();
    clear_inputs();
    reset = 1'b0;
    step();
    n_checks++; if (occupancy !== 5'd0 || iq.iss_valid !== 3'b000) begin n_fail++; $display("[TB] FAIL midrst_after: got occ %0d valid %b want 0/000", occupancy, iq.iss_valid); end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    clear_inputs();
    iq.fu_ready = 3'b000;
    test_reset();
    test_dual_dispatch();
    test_wakeup();
    test_bypass();
    test_age_order();
    test_full();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
# issue_queue

Parametrised, out-of-order reservation station that follows the rename/dispatch stage and precedes the functional units. It accepts up to two renamed instructions per cycle and captures their source operands, either from dispatch or from completion-stage broadcasts. Each cycle it issues at most one ready instruction to every functional unit, oldest first. It generalises the fixed 16-entry station to configurable depth, FU count and broadcast width, and adds age-ordered select, a per-FU ready handshake, same-cycle wakeup bypass and flush.

## Interface
- DEPTH, 16, number of entries (≥2)
- NUM_FU, 3, number of functional-unit issue ports
- CBW, 2, completion broadcast ports
- TAG_W, 6, physical register tag width (64 physical regs)
- ROB_W, 4, ROB index width
- DATA_W, 32, operand width
- CTRL_W, 32, opaque decoded-control payload width
- FU_W, $clog2(NUM_FU) (min 1), FU select width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous; invalidates all entries
- disp_valid  in  2  per-slot dispatch valid; slot 0 is older than slot 1
- disp_ready  out  1  both slots may dispatch this cycle
- disp_src1_tag / disp_src2_tag  in  2*TAG_W  source tags
- disp_src1_rdy / disp_src2_rdy  in  2  source value already valid
- disp_src1_val / disp_src2_val  in  2*DATA_W  source values, meaningful when rdy
- disp_dst_tag  in  2*TAG_W  destination tag
- disp_rob  in  2*ROB_W  ROB index
- disp_fu  in  2*FU_W  target FU (< NUM_FU)
- disp_ctrl  in  2*CTRL_W  control payload
- wb_valid  in  CBW  completion broadcast valid
- wb_tag  in  CBW*TAG_W  completing tag
- wb_val  in  CBW*DATA_W  completing value
- fu_ready  in  NUM_FU  FU k can accept an instruction this cycle
- iss_valid  out  NUM_FU  one-cycle issue pulse per FU
- iss_src1_val / iss_src2_val  out  NUM_FU*DATA_W  operands
- iss_dst_tag  out  NUM_FU*TAG_W;  iss_rob  out  NUM_FU*ROB_W;  iss_ctrl  out  NUM_FU*CTRL_W
- occupancy  out  $clog2(DEPTH+1)  valid-entry count

## Operation
- Entry state: valid, src1/src2 {tag, rdy, val}, dst_tag, rob, fu, ctrl, and relative age (age matrix or equivalent).
- disp_ready = (DEPTH − occupancy) ≥ 2, computed from registered state only. Entries freed by issue in the current cycle are not counted.
- A slot is accepted when disp_valid[s] && disp_ready && !flush. Accepted slots go to the lowest-indexed free entries, slot 0 first. Slot 1 may be valid alone.
- Accepted instructions are younger than every resident entry. Slot 0 is older than slot 1.
- Wakeup: for each valid, not-ready source, a match with any wb_valid[j] && wb_tag[j]==src_tag sets rdy and captures wb_val[j]. On multiple matches, the lowest j wins.
- Bypass: a dispatching source with rdy=0 that matches a same-cycle broadcast is written as ready with wb_val.
- Select, per FU k: among valid entries with fu==k and both sources ready (registered state), pick the oldest. Issue only if fu_ready[k].
- Issue: on the edge, the selected entry is copied to the port-k output registers, iss_valid[k] is set, and the entry is freed. Otherwise iss_valid[k] is cleared.
- An entry issues at most once, and to exactly one FU.
- Flush: at the edge, every entry is invalidated, iss_valid is cleared and same-cycle dispatch is dropped. Broadcasts during flush are ignored.
- occupancy: updated each edge as +accepted − issued. It is 0 after reset or flush.

## Timing
- Reset values: iss_valid=0, all iss_* data=0, occupancy=0, disp_ready=1, all entries invalid. Asserting reset mid-operation takes effect immediately, with no partial issue.
- Dispatch with both sources ready: entry written at edge E0, selected in the following cycle, iss_valid at E1. Minimum latency is 1 cycle.
- Dispatch with a source pending, broadcast in cycle C: rdy is set at the end of C and iss_valid is asserted one edge later. There is no same-cycle wakeup-to-issue.
- Full boundary: occupancy = DEPTH−1 or DEPTH gives disp_ready=0, even if an issue frees an entry that cycle.
- A freed entry can be reallocated on the edge after it issues.
- Dispatch, wakeup and issue can all occur in the same cycle, on independent entries.

## Test plan
- Reset, then dispatch two ready instructions (fu 0 and 1) in one cycle -> both iss_valid bits assert on the next edge with the dispatched vals, dst_tag and rob; occupancy reads 2 then 0.
- Dispatch src1_tag=5, rdy=0 to fu 0. Three cycles later broadcast wb_tag=5, wb_val=0xDEADBEEF -> iss_valid[0] is asserted one edge after the wakeup edge, with iss_src1_val=0xDEADBEEF.
- Dispatch src2_tag=9, rdy=0 in the same cycle as wb_tag=9, wb_val=0x1234 -> the instruction issues on the next edge with src2_val=0x1234 (bypass).
- Fill 3 ready fu-0 entries over 3 cycles with fu_ready[0]=0, then raise fu_ready[0] -> they issue in dispatch order, one per cycle. A slot-0/slot-1 pair issues slot 0 first.
- Fill to DEPTH−1 -> disp_ready=0. Issue one -> disp_ready=1 on the following cycle. Check that no dispatch is accepted while disp_ready=0.
- With 4 waiting entries, assert flush in the same cycle as a dispatch and a broadcast -> occupancy=0 and iss_valid=0 next cycle. Assert reset mid-run -> all outputs return to reset values immediately.
